// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (CPU, DMA) for a single-port data memory with lock ownership,
// DMA starvation guard and registered read return. Define ARB_ROUND_ROBIN_EN for round-robin base policy.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        CPU_LOCK,
        DMA_LOCK
    } owner_e;

    owner_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              force_dma;
    logic              cpu_rd, dma_rd;
    logic              cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = DMA held the last grant; reset to DMA so the CPU wins the first tie.
    logic last_dma_q, last_dma_d;
`endif

    // Grant decision; everything is gated off while reset is asserted.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        force_dma = dma_req && (wait_q == MAX_WAIT_C);
        if (rst_n) begin
            if (force_dma) begin
                dma_gnt = 1'b1;
            end else if (state_q == CPU_LOCK && cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (state_q == DMA_LOCK && dma_req) begin
                dma_gnt = 1'b1;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                if (cpu_req && dma_req) begin
                    cpu_gnt = last_dma_q;
                    dma_gnt = ~last_dma_q;
                end else begin
                    cpu_gnt = cpu_req;
                    dma_gnt = dma_req;
                end
`else
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    dma_gnt = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_gnt && cpu_lock) begin
                    state_d = CPU_LOCK;
                end else if (dma_gnt && dma_lock) begin
                    state_d = DMA_LOCK;
                end
            end
            CPU_LOCK: begin
                if (!cpu_lock || dma_gnt) begin
                    state_d = IDLE;
                end
            end
            DMA_LOCK: begin
                if (!dma_lock || cpu_gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (!dma_req || dma_gnt) begin
            wait_d = '0;
        end else if (wait_q != MAX_WAIT_C) begin
            wait_d = wait_q + 4'd1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_dma_d = last_dma_q;
        if (cpu_gnt) begin
            last_dma_d = 1'b0;
        end else if (dma_gnt) begin
            last_dma_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dma_q <= 1'b1;
        end else begin
            last_dma_q <= last_dma_d;
        end
    end
`endif

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (cpu_gnt) begin
            mem_access_addr = cpu_addr;
            mem_write_data  = cpu_wdata;
            mem_write_en    = cpu_we;
            mem_read        = ~cpu_we;
        end else if (dma_gnt) begin
            mem_access_addr = dma_addr;
            mem_write_data  = dma_wdata;
            mem_write_en    = dma_we;
            mem_read        = ~dma_we;
        end
    end

    assign cpu_rd = cpu_gnt & ~cpu_we;
    assign dma_rd = dma_gnt & ~dma_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cpu_rvalid_q <= cpu_rd;
            dma_rvalid_q <= dma_rd;
            if (cpu_rd) begin
                cpu_rdata_q <= mem_read_data;
            end
            if (dma_rd) begin
                dma_rdata_q <= mem_read_data;
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory.
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_lock;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we, dma_lock;
    logic [7:0]  dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [15:0] dma_rdata;
    logic [7:0]  mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en, mem_read;
    logic [15:0] mem_read_data;

    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;
    logic exp_c [6];
    logic exp_d [6];

    always #5 clk = ~clk;

    // Preload happens while reset is held; writes only from the arbiter afterwards.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[3] <= 16'h1234;
        end else if (mem_write_en) begin
            mem[mem_access_addr] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr];

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        // Last grant before contention is the CPU, so the DMA goes first.
        exp_c = '{0, 1, 0, 1, 0, 1};
        exp_d = '{1, 0, 1, 0, 1, 0};
`else
        exp_c = '{1, 1, 1, 1, 0, 1};
        exp_d = '{0, 0, 0, 0, 1, 0};
`endif
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_lock = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 8'h00; dma_wdata = 16'h0000;

        // Reset behaviour
        tick; tick;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_mem_addr", mem_access_addr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_cpu_gnt", cpu_gnt, 1);
        chk("rel_mem_we", mem_write_en, 1);
        chk("rel_mem_wdata", mem_write_data, 16'hBEEF);
        tick;

        // Read back the address written the previous cycle
        cpu_we = 1'b0;
        #1;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_read", mem_read, 1);
        chk("wr_no_rvalid", cpu_rvalid, 0);
        tick;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;
        #1;
        chk("idle_gnt", cpu_gnt | dma_gnt, 0);
        chk("idle_mem_read", mem_read, 0);
        chk("idle_mem_addr", mem_access_addr, 0);
        tick;
        chk("rvalid_pulse", cpu_rvalid, 0);
        chk("rdata_hold", cpu_rdata, 16'hBEEF);

        // Continuous contention
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h03;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont_cpu_gnt%0d", i), cpu_gnt, exp_c[i]);
            chk($sformatf("cont_dma_gnt%0d", i), dma_gnt, exp_d[i]);
            tick;
            chk($sformatf("cont_dma_rvalid%0d", i), dma_rvalid, exp_d[i]);
            chk($sformatf("cont_cpu_rvalid%0d", i), cpu_rvalid, exp_c[i]);
            if (exp_d[i]) chk($sformatf("cont_dma_rdata%0d", i), dma_rdata, 16'h1234);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick;

        // DMA lock holds off the CPU until dma_lock drops
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 16'hA5A5;
        #1;
        chk("lk_dma_gnt", dma_gnt, 1);
        chk("lk_mem_we", mem_write_en, 1);
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lk_hold_dma%0d", i), dma_gnt, 1);
            chk($sformatf("lk_hold_cpu%0d", i), cpu_gnt, 0);
            tick;
        end
        dma_lock = 1'b0;
        #1;
        chk("lk_last_dma", dma_gnt, 1);
        tick;
        chk("lk_cpu_after", cpu_gnt, 1);
        chk("lk_dma_after", dma_gnt, 0);
        cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        tick;

        // Idle CPU lock owner does not block the DMA
        cpu_req = 1'b1; cpu_lock = 1'b1;
        #1;
        chk("ol_cpu_gnt", cpu_gnt, 1);
        tick;
        cpu_req = 1'b0; dma_req = 1'b1; dma_addr = 8'h03;
        #1;
        chk("ol_dma_gnt", dma_gnt, 1);
        chk("ol_cpu_gnt0", cpu_gnt, 0);
        chk("ol_mem_addr", mem_access_addr, 8'h03);
        tick;
        chk("ol_dma_rvalid", dma_rvalid, 1);
        dma_lock = 1'b1;
        #1;
        chk("ol_dma_take", dma_gnt, 1);
        tick;
        cpu_req = 1'b1;
        #1;
        chk("ol_dma_owns", dma_gnt, 1);
        chk("ol_cpu_blocked", cpu_gnt, 0);
        cpu_req = 1'b0; dma_req = 1'b0; cpu_lock = 1'b0; dma_lock = 1'b0;
        tick;

        // Reset mid-operation clears rvalid and suppresses the pending write
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick;
        chk("mr_rvalid_before", cpu_rvalid, 1);
        cpu_we = 1'b1; cpu_wdata = 16'hDEAD; rst_n = 1'b0;
        #1;
        chk("mr_rvalid_clr", cpu_rvalid, 0);
        chk("mr_mem_we", mem_write_en, 0);
        chk("mr_cpu_gnt", cpu_gnt, 0);
        tick;
        cpu_req = 1'b0; rst_n = 1'b1;
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0;
        #1;
        chk("mr_rd_gnt", cpu_gnt, 1);
        tick;
        chk("mr_rd_rvalid", cpu_rvalid, 1);
        chk("mr_rd_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
